// File: rtl/render_queue_ctrl.sv
// render_queue_ctrl: assembles 48-bit sprite commands from 16-bit bus writes and releases them to the display one committed frame at a time
// Optional: define RENDER_QUEUE_REPLAY_EN to keep the last committed frame and replay it until a newer frame is committed.
module render_queue_ctrl #(
  parameter int DEPTH = 25,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        render_queue_pop_front,
  output logic [47:0] render_queue_dout
);
  localparam logic [47:0] MARKER = {8'hFF, 40'h0};
  typedef enum logic [1:0] {IDLE, HAVE_LO, HAVE_MID} state_t;
  state_t state_q, state_d;
  logic [15:0] lo_q, lo_d, mid_q, mid_d, readdata_q, readdata_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, cmt_q, cmt_d, base_q, base_d;
  logic full_q, full_d, ovf_q, ovf_d, seq_q, seq_d;
  logic [47:0] mem_q [DEPTH];
  logic wr_en, rd_en, push_req, push_ok, pop_ok, base_adv, avail;
  logic [7:0] count;
  logic [47:0] head;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_en = chipselect && write;
  assign rd_en = chipselect && read;
  assign avail = rd_q != cmt_q;
  assign head = mem_q[rd_q];
  assign render_queue_dout = avail ? head : MARKER;
  assign readdata = readdata_q;
  assign readdata_d = rd_en ? ((address == 2'd3) ? {ovf_q, seq_q, 6'b0, count} : 16'h0) : readdata_q;

  // occupancy from base to wr; the full flag separates a full ring from an empty one
  always_comb begin
    count = full_q ? 8'(DEPTH) : (wr_q >= base_q) ? 8'(wr_q - base_q) : 8'(DEPTH + int'(wr_q) - int'(base_q));
  end

  // command assembly FSM plus sticky error flags; an out-of-order half is dropped
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    mid_d = mid_q;
    seq_d = seq_q;
    ovf_d = ovf_q;
    push_req = 1'b0;
    if (wr_en) begin
      if (address == 2'd0) begin
        lo_d = writedata;
        state_d = HAVE_LO;
      end else if (address == 2'd1) begin
        mid_d = (state_q == HAVE_LO) ? writedata : mid_q;
        seq_d = seq_q || (state_q != HAVE_LO);
        state_d = (state_q == HAVE_LO) ? HAVE_MID : IDLE;
      end else if (address == 2'd2) begin
        push_req = state_q == HAVE_MID;
        seq_d = seq_q || (state_q != HAVE_MID);
        state_d = IDLE;
      end else begin
        seq_d = 1'b0;
        ovf_d = 1'b0;
      end
    end
    if (push_req && full_q) ovf_d = 1'b1;
  end

  // ring pointers: a marker push commits the frame, pops walk rd and free entries behind it
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    cmt_d = cmt_q;
    base_d = base_q;
    base_adv = 1'b0;
    push_ok = push_req && !full_q;
    pop_ok = render_queue_pop_front && avail;
    if (push_ok) begin
      wr_d = inc(wr_q);
      cmt_d = (writedata[15:8] == 8'hFF) ? inc(wr_q) : cmt_q;
    end
`ifdef RENDER_QUEUE_REPLAY_EN
    if (pop_ok && head[47:40] == 8'hFF && inc(rd_q) == cmt_q) begin
      rd_d = base_q;
    end else if (pop_ok && head[47:40] == 8'hFF) begin
      rd_d = inc(rd_q);
      base_d = inc(rd_q);
      base_adv = 1'b1;
    end else if (pop_ok) begin
      rd_d = inc(rd_q);
    end
`else
    if (pop_ok) begin
      rd_d = inc(rd_q);
      base_d = inc(rd_q);
      base_adv = 1'b1;
    end
`endif
    full_d = base_adv ? 1'b0 : push_ok ? (wr_d == base_q) : full_q;
  end

  // control state; reset drops every entry including a half-built command
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q <= '0;
      mid_q <= '0;
      readdata_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cmt_q <= '0;
      base_q <= '0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      seq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      mid_q <= mid_d;
      readdata_q <= readdata_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cmt_q <= cmt_d;
      base_q <= base_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
      seq_q <= seq_d;
    end
  end

  // command storage; contents are only observed behind committed pointers so no reset is needed
  always_ff @(posedge clk50) begin
    if (push_ok) mem_q[wr_q] <= {writedata, mid_q, lo_q};
  end
endmodule
